// File: rtl/memory_bus_sequencer_if.sv
// memory_bus_sequencer_if: request, response and memory bus signals of the bus sequencer
interface memory_bus_sequencer_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  ifetch_req;
  logic [ADDR_WIDTH-1:0] ifetch_addr;
  logic                  data_req;
  logic                  data_we;
  logic [ADDR_WIDTH-1:0] data_addr;
  logic [DATA_WIDTH-1:0] data_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_rd;
  logic                  mem_wr;
  logic [DATA_WIDTH-1:0] instr;
  logic                  instr_valid;
  logic [DATA_WIDTH-1:0] data_rdata;
  logic                  data_done;
  logic                  bus_err;
  logic                  stall;
  modport master (
    input  ifetch_req, ifetch_addr, data_req, data_we, data_addr, data_wdata, mem_rdata, mem_ready,
    output mem_addr, mem_wdata, mem_rd, mem_wr, instr, instr_valid, data_rdata, data_done, bus_err, stall
  );
  modport slave (
    output ifetch_req, ifetch_addr, data_req, data_we, data_addr, data_wdata, mem_rdata, mem_ready,
    input  mem_addr, mem_wdata, mem_rd, mem_wr, instr, instr_valid, data_rdata, data_done, bus_err, stall
  );
endinterface

// File: rtl/memory_bus_sequencer.sv
// memory_bus_sequencer: shares one memory bus between instruction fetch and data load/store
module memory_bus_sequencer #(
  parameter int WAIT_STATES = 1,
  parameter int TIMEOUT     = 64
) (
  input logic                   clk,
  input logic                   reset,
  memory_bus_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
  typedef enum logic [1:0] {FETCH, LOAD, STORE} op_t;
  state_t     state;
  op_t        op;
  logic [3:0] wait_cnt;
  logic [7:0] to_cnt;
  // stall is masked by reset so every output reads 0 while reset is held
  assign bus.stall = reset && (state == ACCESS || (state == IDLE && (bus.ifetch_req || bus.data_req)));
  // sequencer: arbitrate in IDLE, run wait states and timeout in ACCESS, pulse results in ACK
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      op             <= FETCH;
      wait_cnt       <= '0;
      to_cnt         <= '0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.mem_rd     <= 1'b0;
      bus.mem_wr     <= 1'b0;
      bus.instr      <= '0;
      bus.instr_valid <= 1'b0;
      bus.data_rdata <= '0;
      bus.data_done  <= 1'b0;
      bus.bus_err    <= 1'b0;
    end else begin
      bus.instr_valid <= 1'b0;
      bus.data_done   <= 1'b0;
      bus.bus_err     <= 1'b0;
      case (state)
        IDLE: begin
          wait_cnt <= 4'(WAIT_STATES);
          to_cnt   <= '0;
          if (bus.data_req) begin
            state        <= ACCESS;
            op           <= bus.data_we ? STORE : LOAD;
            bus.mem_addr <= bus.data_addr;
            bus.mem_rd   <= !bus.data_we;
            bus.mem_wr   <= bus.data_we;
            if (bus.data_we) bus.mem_wdata <= bus.data_wdata;
          end else if (bus.ifetch_req) begin
            state        <= ACCESS;
            op           <= FETCH;
            bus.mem_addr <= bus.ifetch_addr;
            bus.mem_rd   <= 1'b1;
          end
        end
        ACCESS: begin
          if (wait_cnt != 0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else if (bus.mem_ready || to_cnt == 8'(TIMEOUT - 1)) begin
            state           <= ACK;
            bus.mem_rd      <= 1'b0;
            bus.mem_wr      <= 1'b0;
            bus.bus_err     <= !bus.mem_ready;
            bus.instr_valid <= op == FETCH;
            bus.data_done   <= op != FETCH;
            if (bus.mem_ready && op == FETCH) bus.instr <= bus.mem_rdata;
            if (bus.mem_ready && op == LOAD) bus.data_rdata <= bus.mem_rdata;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
